map_gen: RTL and testbench
==========================

Name: map_gen

Overview:
- Writer side of the cell-map interface: fills a CELLS_X x CELLS_Y cell map with pseudo-random content using an LFSR, one cell per clock.
- Holds the map in internal RAM and exposes a registered read port; the VGA draw stages read cells through it by hcount/vcount-derived address.
- Started by game logic with a start/busy/done handshake.

Parameters:
- CELLS_X, 32, map width in cells
- CELLS_Y, 24, map height in cells
- FILL_THRESHOLD, 8'd96, a block is placed when lfsr[7:0] < FILL_THRESHOLD (probability out of 256)
- DEFAULT_SEED, 16'hACE1, seed used after reset and when a zero seed is loaded

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request generation; sampled only in IDLE
- seed_load  in  1  load seed_in into LFSR; honoured only in IDLE
- seed_in  in  16  new seed value
- busy  out  1  high while generating
- done  out  1  one-cycle pulse when the map is complete
- map_valid  out  1  high when the map holds a complete, generated map
- rd_addr  in  ADDR_W  read address = y*CELLS_X + x; ADDR_W = $clog2(CELLS_X*CELLS_Y) = 10
- rd_data  out  2  cell type at rd_addr, one-cycle latency

Behaviour:
- Reset (synchronous, active high): state=IDLE; busy=0; done=0; map_valid=0; rd_data=CELL_EMPTY; LFSR=DEFAULT_SEED; x/y counters=0. RAM contents are not cleared.
- Cell encoding: CELL_EMPTY=2'b00, CELL_WALL=2'b01, CELL_BLOCK=2'b10. 2'b11 is reserved and never written.
- LFSR: 16-bit Galois, taps 16'hB400. It advances once per GEN cycle and holds otherwise.
- Seed loading: seed_load in IDLE loads seed_in. If seed_in==0, DEFAULT_SEED is loaded instead, so the LFSR never locks up. If seed_load and start are high in the same cycle, the seed is loaded first and generation uses the new seed.
- State machine, IDLE:
  - start=1 -> GEN next cycle.
  - On that transition: x=0, y=0, map_valid<=0, busy<=1.
- State machine, GEN: each cycle, write one cell at address y*CELLS_X+x, then increment x. When x wraps from CELLS_X-1 to 0, y increments. After cell (CELLS_X-1, CELLS_Y-1) is written, go to FIN.
- State machine, FIN (1 cycle): busy<=0, done<=1 for exactly one cycle, map_valid<=1, then go to IDLE.
- Cell write value, first matching rule wins:
  1. Border (x==0, x==CELLS_X-1, y==0 or y==CELLS_Y-1) -> WALL.
  2. Spawn cells (1,1),(2,1),(1,2) and the mirror cells (CELLS_X-2,CELLS_Y-2),(CELLS_X-3,CELLS_Y-2),(CELLS_X-2,CELLS_Y-3) -> EMPTY.
  3. Otherwise, lfsr[7:0] < FILL_THRESHOLD -> BLOCK, else EMPTY.
- Latency: busy rises 1 cycle after start. Exactly CELLS_X*CELLS_Y (768) GEN cycles follow, then done pulses on the next cycle. Start-to-done is 770 cycles.
- Determinism: the same seed always produces an identical map.
- start while busy or in FIN is ignored; it is not queued.
- Read port: synchronous, read-first. A simultaneous read and write to the same address returns the old data. rd_addr >= CELLS_X*CELLS_Y returns CELL_EMPTY. Reads are allowed at all times; the map is only guaranteed complete while map_valid=1.
- Reset mid-GEN: returns to IDLE next cycle with map_valid=0. The partially written map stays in RAM but is flagged invalid.

Decomposition:
- Shared package (game_pkg): CELL_EMPTY, CELL_WALL and CELL_BLOCK as a cell_t enum; CELLS_X, CELLS_Y and CELL_SIZE constants; ADDR_W. The draw stage and map_gen use the same constants from this package.
- Sub-module lfsr16: seed load, enable and zero-seed guard. The RAM is inferred inside map_gen.

Test Plan:
- Reset, then idle 10 cycles -> busy=0, done=0, map_valid=0, rd_data=2'b00 for any address.
- start pulse with DEFAULT_SEED -> busy=1 at T+1, done pulse only at T+770, map_valid=1 afterwards.
  - Read all 768 addresses: every border cell = 2'b01, cells (1,1),(2,1),(1,2),(30,22),(29,22),(30,21) = 2'b00.
  - No cell = 2'b11.
  - BLOCK count matches the reference model.
- seed_load with seed_in=16'h1234 then generate, twice -> both maps bit-identical. Regenerate with 16'h4321 -> maps differ. seed_in=0 -> map equals the DEFAULT_SEED map.
- FILL_THRESHOLD=0 -> no BLOCK cells. FILL_THRESHOLD=255 -> every non-border, non-spawn cell except those with lfsr[7:0]=8'hFF is BLOCK.
- start asserted again at cycle 100 of GEN -> ignored, done still at 770. rd_addr=768 and rd_addr=1023 -> rd_data=2'b00.
- rst at cycle 300 of GEN -> next cycle busy=0, map_valid=0, no done pulse. A new start then completes normally in 770 cycles.

Source files
------------

// File: rtl/map_gen_pkg.sv
// Shared constants, cell encoding and helpers for the cell map writer and the draw stages.
package map_gen_pkg;

  localparam int CELLS_X   = 32;
  localparam int CELLS_Y   = 24;
  localparam int CELL_SIZE = 20;
  localparam int N_CELLS   = CELLS_X * CELLS_Y;
  localparam int ADDR_W    = $clog2(N_CELLS);
  localparam int XW        = $clog2(CELLS_X);
  localparam int YW        = $clog2(CELLS_Y);

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_WALL  = 2'b01,
    CELL_BLOCK = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(CELLS_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(CELLS_Y - 1);

  function automatic logic is_border(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
  endfunction

  // Spawn pockets in two opposite corners are always kept clear.
  function automatic logic is_spawn(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ((x == XW'(1))           && (y == YW'(1)))           ||
           ((x == XW'(2))           && (y == YW'(1)))           ||
           ((x == XW'(1))           && (y == YW'(2)))           ||
           ((x == XW'(CELLS_X - 2)) && (y == YW'(CELLS_Y - 2))) ||
           ((x == XW'(CELLS_X - 3)) && (y == YW'(CELLS_Y - 2))) ||
           ((x == XW'(CELLS_X - 2)) && (y == YW'(CELLS_Y - 3)));
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/map_gen_lfsr16.sv
// 16-bit Galois LFSR with seed load and a guard that never lets it hold zero.
module map_gen_lfsr16
  import map_gen_pkg::*;
#(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [7:0]  rand_byte
);

  logic [15:0] value;

  // Seed load wins over stepping; a zero seed falls back to the default.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= DEFAULT_SEED;
    end else if (load) begin
      value <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (en) begin
      value <= lfsr_step(value);
    end
  end

  assign rand_byte = value[7:0];

endmodule

// File: rtl/map_gen.sv
// Cell map writer: fills the map with walls, spawn pockets and random blocks, one cell per clock,
// and serves a registered read port to the draw stages.
module map_gen
  import map_gen_pkg::*;
#(
  parameter logic [7:0]  FILL_THRESHOLD = 8'd96,
  parameter logic [15:0] DEFAULT_SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              seed_load,
  input  logic [15:0]       seed_in,
  output logic              busy,
  output logic              done,
  output logic              map_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_data
);

  state_t            state, state_nxt;
  logic              busy_nxt, done_nxt, map_valid_nxt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [7:0]        rand_byte;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  cell_t             cell_wr;
  logic [1:0]        mem [N_CELLS];

  map_gen_lfsr16 #(
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load && (state == ST_IDLE)),
    .seed     (seed_in),
    .en       (state == ST_GEN),
    .rand_byte(rand_byte)
  );

  // State and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      map_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      map_valid <= map_valid_nxt;
    end
  end

  // Next-state decode; start outside IDLE is dropped, not queued.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_GEN;
      ST_GEN:  if ((x == X_LAST) && (y == Y_LAST)) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the handshake outputs; done lands the cycle after FIN.
  always_comb begin
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    map_valid_nxt = map_valid;
    case (state)
      ST_IDLE: begin
        if (start) begin
          busy_nxt      = 1'b1;
          map_valid_nxt = 1'b0;
        end
      end
      ST_FIN: begin
        busy_nxt      = 1'b0;
        done_nxt      = 1'b1;
        map_valid_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Raster-order cell position, cleared when a new map is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if ((state == ST_IDLE) && start) begin
      x <= '0;
      y <= '0;
    end else if (state == ST_GEN) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Cell content priority: border wall, then clear spawn pocket, then random block.
  always_comb begin
    cell_wr = CELL_EMPTY;
    if (is_border(x, y)) begin
      cell_wr = CELL_WALL;
    end else if (is_spawn(x, y)) begin
      cell_wr = CELL_EMPTY;
    end else if (rand_byte < FILL_THRESHOLD) begin
      cell_wr = CELL_BLOCK;
    end
  end

  assign wr_addr = ADDR_W'(y) * ADDR_W'(CELLS_X) + ADDR_W'(x);
  assign wr_en   = (state == ST_GEN);

  // Map RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= cell_wr;
    end
  end

  // Registered read-first port; addresses beyond the map read as empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= CELL_EMPTY;
    end else if (rd_addr < ADDR_W'(N_CELLS)) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= CELL_EMPTY;
    end
  end

endmodule

// File: tb/tb_map_gen.sv
// Scoreboard bench for map_gen: three instances (threshold 96, 0, 255) driven in lockstep.
module tb_map_gen;
  import map_gen_pkg::*;

  typedef logic [1:0] map_t [N_CELLS];
  typedef struct {
    int         addr;
    logic [1:0] a;
    logic [1:0] z;
    logic [1:0] f;
  } rd_exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              seed_load = 1'b0;
  logic [15:0]       seed_in = 16'h0000;
  logic [ADDR_W-1:0] rd_addr = 10'd768;
  logic              rd_req = 1'b0;
  logic              rd_req_d = 1'b0;

  logic busy_a, done_a, valid_a, busy_z, done_z, valid_z, busy_f, done_f, valid_f;
  logic [1:0] rd_a, rd_z, rd_f;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int      done_q[$];
  rd_exp_t rd_q[$];
  map_t    ea, ez, ef, cap, m_def, m1, m2, m3, m4;
  int      model_blocks;

  map_gen #(.FILL_THRESHOLD(8'd96), .DEFAULT_SEED(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_a), .done(done_a), .map_valid(valid_a), .rd_addr(rd_addr), .rd_data(rd_a));

  map_gen #(.FILL_THRESHOLD(8'd0), .DEFAULT_SEED(16'hACE1)) u_zero (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_z), .done(done_z), .map_valid(valid_z), .rd_addr(rd_addr), .rd_data(rd_z));

  map_gen #(.FILL_THRESHOLD(8'd255), .DEFAULT_SEED(16'hACE1)) u_full (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_f), .done(done_f), .map_valid(valid_f), .rd_addr(rd_addr), .rd_data(rd_f));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_req_d <= rd_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_cell(input int x, input int y, input logic [7:0] b, input int thr);
    if (x == 0 || x == 31 || y == 0 || y == 23) return 2'b01;
    if ((x == 1 && y == 1) || (x == 2 && y == 1) || (x == 1 && y == 2) ||
        (x == 30 && y == 22) || (x == 29 && y == 22) || (x == 30 && y == 21)) return 2'b00;
    return (int'(b) < thr) ? 2'b10 : 2'b00;
  endfunction

  function automatic int ndiff(input map_t a, input map_t b);
    int n = 0;
    for (int i = 0; i < N_CELLS; i++) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  function automatic int count_of(input map_t m, input logic [1:0] v);
    int n = 0;
    for (int i = 0; i < N_CELLS; i++) if (m[i] === v) n++;
    return n;
  endfunction

  // Reference map: cell k is decided by the LFSR value after k steps from the seed.
  task automatic build_model(input logic [15:0] seed);
    logic [15:0] l;
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    model_blocks = 0;
    for (int k = 0; k < N_CELLS; k++) begin
      ea[k] = ref_cell(k % 32, k / 32, l[7:0], 96);
      ez[k] = ref_cell(k % 32, k / 32, l[7:0], 0);
      ef[k] = ref_cell(k % 32, k / 32, l[7:0], 255);
      if (ea[k] == 2'b10) model_blocks++;
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed_in   = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Issue start and wait for map_valid; restart_at >= 0 re-pulses start (and a stray seed_load) mid-GEN.
  task automatic run_gen(input logic [15:0] mseed, input int restart_at);
    int n;
    build_model(mseed);
    done_q.push_back(cyc + 770);
    start = 1'b1;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    chk("busy_rise", busy_a, 1);
    chk("valid_cleared", valid_a, 0);
    n = 1;
    while (!valid_a && n < 800) begin
      if (n == restart_at) begin
        start = 1'b1; seed_load = 1'b1; seed_in = 16'h4321;
      end
      tick();
      if (n == restart_at) begin
        start = 1'b0; seed_load = 1'b0;
        chk("busy_hold_on_restart", busy_a, 1);
      end
      n++;
    end
    chk("map_valid_set", {valid_a, valid_z, valid_f}, 3'b111);
    chk("busy_fall", {busy_a, busy_z, busy_f}, 3'b000);
  endtask

  task automatic read_map();
    for (int a = 0; a < N_CELLS; a++) begin
      rd_addr = 10'(a);
      rd_req  = 1'b1;
      rd_q.push_back('{a, ea[a], ez[a], ef[a]});
      tick();
    end
    rd_req  = 1'b0;
    rd_addr = 10'd768;
    tick();
  endtask

  task automatic check_static(input string tag);
    int sp [6] = '{33, 34, 65, 734, 733, 702};
    chk({tag, "_wall_count"}, count_of(cap, 2'b01), 108);
    chk({tag, "_reserved"}, count_of(cap, 2'b11), 0);
    chk({tag, "_block_count"}, count_of(cap, 2'b10), model_blocks);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_spawn_%0d", tag, sp[i]), cap[sp[i]], 0);
  endtask

  // Monitor: pops expected read data and expected done cycles as the DUTs present them.
  always @(negedge clk) begin
    rd_exp_t e;
    int      exp_cyc;
    if (rd_req_d) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got read data with nothing expected at cycle %0d", cyc);
      end else begin
        e = rd_q.pop_front();
        chk($sformatf("rd96@%0d", e.addr), rd_a, e.a);
        chk($sformatf("rd0@%0d", e.addr), rd_z, e.z);
        chk($sformatf("rd255@%0d", e.addr), rd_f, e.f);
        cap[e.addr] = rd_a;
      end
    end
    if (done_a || done_z || done_f) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_cyc = done_q.pop_front();
        chk("done_cycle", cyc, exp_cyc);
        chk("done_all", {done_a, done_z, done_f}, 3'b111);
      end
    end
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("reset_busy", {busy_a, busy_z, busy_f}, 3'b000);
    chk("reset_done", {done_a, done_z, done_f}, 3'b000);
    chk("reset_valid", {valid_a, valid_z, valid_f}, 3'b000);
    chk("reset_rd_768", rd_a, 0);
    rd_addr = 10'd1023;
    tick();
    chk("reset_rd_1023", rd_a, 0);

    // Default seed straight out of reset.
    run_gen(16'hACE1, -1);
    read_map();
    m_def = cap;
    check_static("def");
    chk("rd_oob_768", rd_a, 0);
    rd_addr = 10'd1023;
    tick();
    chk("rd_oob_1023", rd_a, 0);

    // Determinism and seed sensitivity.
    do_seed(16'h1234);
    run_gen(16'h1234, -1);
    read_map();
    m1 = cap;
    check_static("s1234a");
    do_seed(16'h1234);
    run_gen(16'h1234, -1);
    read_map();
    m2 = cap;
    chk("same_seed_identical", ndiff(m1, m2), 0);
    do_seed(16'h4321);
    run_gen(16'h4321, -1);
    read_map();
    m3 = cap;
    chk("diff_seed_differs", ndiff(m1, m3) != 0, 1);

    // Zero seed loaded in the same cycle as start falls back to the default seed.
    seed_in   = 16'h0000;
    seed_load = 1'b1;
    run_gen(16'h0000, -1);
    read_map();
    m4 = cap;
    chk("zero_seed_is_default", ndiff(m4, m_def), 0);

    // Start and seed_load during GEN are ignored.
    do_seed(16'h1234);
    run_gen(16'h1234, 100);
    read_map();
    chk("restart_ignored_map", ndiff(cap, m1), 0);
    repeat (5) tick();

    // Reset in the middle of generation: no done, map flagged invalid.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_busy_rise", busy_a, 1);
    repeat (299) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {busy_a, busy_z, busy_f}, 3'b000);
    chk("mid_rst_valid", {valid_a, valid_z, valid_f}, 3'b000);
    repeat (5) tick();
    chk("mid_rst_still_idle", busy_a, 0);

    // Fresh start after reset runs from the default seed again.
    run_gen(16'hACE1, -1);
    read_map();
    check_static("post_rst");
    chk("post_rst_is_default", ndiff(cap, m_def), 0);

    repeat (5) tick();
    chk("done_q_empty", done_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
